// File: rtl/fir_pipeline_mc.sv
// fir_pipeline_mc: multi-channel, fully pipelined FIR filter.
// Each channel owns a delay line and all channels share one run-time loadable
// coefficient bank. The products feed a registered adder tree, and a final output
// register follows the tree.
// Optional build macro FIR_SYMMETRIC_EN: symmetric coefficient bank with a
// registered pre-adder, which roughly halves the multiplier count.
module fir_pipeline_mc #(
    parameter int  DATA_IN_WIDTH  = 16,
    parameter int  TAP_WIDTH      = 32,
    parameter int  DATA_OUT_WIDTH = 64,
    parameter int  TAP_COUNT      = 16,
    parameter int  CHANNELS       = 2,
    localparam int CH_WIDTH       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int ADDR_WIDTH     = $clog2(TAP_COUNT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic [CH_WIDTH-1:0]              in_channel,
    input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
    input  logic                             coef_wr_en,
    input  logic [ADDR_WIDTH-1:0]            coef_wr_addr,
    input  logic signed [TAP_WIDTH-1:0]      coef_wr_data,
    output logic                             out_valid,
    output logic [CH_WIDTH-1:0]              out_channel,
    output logic signed [DATA_OUT_WIDTH-1:0] data_out,
    output logic                             ch_err
);

`ifdef FIR_SYMMETRIC_EN
    localparam int N_MUL       = (TAP_COUNT + 1) / 2;
    localparam int MUL_A_WIDTH = DATA_IN_WIDTH + 1;
`else
    localparam int N_MUL       = TAP_COUNT;
    localparam int MUL_A_WIDTH = DATA_IN_WIDTH;
`endif
    localparam int LEVELS     = $clog2(N_MUL);
    localparam int PROD_WIDTH = MUL_A_WIDTH + TAP_WIDTH;
    localparam int IDX_WIDTH  = (N_MUL > 1) ? $clog2(N_MUL) : 1;

    typedef logic signed [DATA_IN_WIDTH-1:0]  sample_t;
    typedef logic signed [TAP_WIDTH-1:0]      coef_t;
    typedef logic signed [MUL_A_WIDTH-1:0]    mul_a_t;
    typedef logic signed [PROD_WIDTH-1:0]     prod_t;
    typedef logic signed [DATA_OUT_WIDTH-1:0] acc_t;

    // Number of operands present at a given tree level (level 0 = products).
    function automatic int level_count(input int level);
        int n;
        n = N_MUL;
        for (int i = 0; i < level; i++) n = (n + 1) / 2;
        return n;
    endfunction

    // Index of the first node of a level in the flattened tree storage.
    function automatic int node_offset(input int level);
        int off;
        off = 0;
        for (int i = 0; i < level; i++) off += level_count(i);
        return off;
    endfunction

    localparam int NODES = node_offset(LEVELS + 1);
    localparam int ROOT  = node_offset(LEVELS);

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    logic ch_ok;
    logic accept;

    assign ch_ok  = int'(in_channel) < CHANNELS;
    assign accept = in_valid && ch_ok;

    // ------------------------------------------------------------------
    // Coefficient bank
    // ------------------------------------------------------------------
    coef_t                coef_q [N_MUL];
    logic                 coef_hit;
    logic [IDX_WIDTH-1:0] coef_idx;

    // Map a tap address onto its coefficient register; out-of-range addresses are dropped.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        coef_hit = coef_wr_en && (int'(coef_wr_addr) < TAP_COUNT);
        coef_idx = IDX_WIDTH'(coef_wr_addr);
`ifdef FIR_SYMMETRIC_EN
        if (int'(coef_wr_addr) >= N_MUL)
            coef_idx = IDX_WIDTH'(TAP_COUNT - 1 - int'(coef_wr_addr));
`endif
    end

    // Coefficient register file, written one entry per cycle.
    // NOTE: registers use <= so every stage samples pre-edge values regardless of block order.
    // NOTE: the bank and delay lines are reset because their contents are architecturally
    //       visible; pipeline data registers are not, since their valid bits gate them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_MUL; i++) coef_q[i] <= '0;
        end else if (coef_hit) begin
            coef_q[coef_idx] <= coef_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel delay lines and tap window
    // ------------------------------------------------------------------
    sample_t delay_q [CHANNELS][TAP_COUNT-1];
    sample_t win     [TAP_COUNT];

    // The window seen by the taps is the new sample followed by that channel's history.
    always_comb begin
        win[0] = data_in;
        for (int i = 1; i < TAP_COUNT; i++) win[i] = delay_q[in_channel][i-1];
    end

    // Shift only the addressed channel; the other channels keep their history.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int i = 0; i < TAP_COUNT - 1; i++) delay_q[c][i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < TAP_COUNT - 1; i++) delay_q[in_channel][i] <= win[i];
        end
    end

    // ------------------------------------------------------------------
    // Multiplier operands
    // ------------------------------------------------------------------
    mul_a_t              mul_a [N_MUL];
    coef_t               mul_c [N_MUL];
    logic                mul_v;
    logic [CH_WIDTH-1:0] mul_ch;

`ifdef FIR_SYMMETRIC_EN
    mul_a_t              pre_q      [N_MUL];
    coef_t               pre_coef_q [N_MUL];
    logic                pre_v_q;
    logic [CH_WIDTH-1:0] pre_ch_q;

    // Fold mirrored taps and keep the coefficients in force when the sample was accepted.
    always_ff @(posedge clk) begin
        for (int j = 0; j < N_MUL; j++) begin
            if (2 * j + 1 == TAP_COUNT)
                pre_q[j] <= mul_a_t'(win[j]);
            else
                pre_q[j] <= mul_a_t'(win[j]) + mul_a_t'(win[TAP_COUNT-1-j]);
            pre_coef_q[j] <= coef_q[j];
        end
        pre_ch_q <= in_channel;
        if (reset) pre_v_q <= 1'b0;
        else       pre_v_q <= accept;
    end

    // Multipliers take the pre-added samples and their snapshotted coefficients.
    always_comb begin
        for (int j = 0; j < N_MUL; j++) begin
            mul_a[j] = pre_q[j];
            mul_c[j] = pre_coef_q[j];
        end
    end

    assign mul_v  = pre_v_q;
    assign mul_ch = pre_ch_q;
`else
    // Multipliers take the window directly with the current coefficient bank.
    always_comb begin
        for (int j = 0; j < N_MUL; j++) begin
            mul_a[j] = mul_a_t'(win[j]);
            mul_c[j] = coef_q[j];
        end
    end

    assign mul_v  = accept;
    assign mul_ch = in_channel;
`endif

    // ------------------------------------------------------------------
    // Products and adder tree (flattened: level k starts at node_offset(k))
    // ------------------------------------------------------------------
    acc_t                node_q   [NODES];
    logic [LEVELS:0]     lvl_v_q;
    logic [CH_WIDTH-1:0] lvl_ch_q [LEVELS+1];

    for (genvar j = 0; j < N_MUL; j++) begin : g_mul
        // Full-precision signed product, sign-extended to the accumulator width.
        always_ff @(posedge clk)
            node_q[j] <= acc_t'(prod_t'(mul_a[j]) * prod_t'(mul_c[j]));
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        for (genvar j = 0; j < level_count(k); j++) begin : g_node
            if (2 * j + 1 < level_count(k - 1)) begin : g_add
                // Pairwise sum; wraps in two's complement.
                always_ff @(posedge clk)
                    node_q[node_offset(k) + j] <= node_q[node_offset(k-1) + 2*j]
                                                + node_q[node_offset(k-1) + 2*j + 1];
            end else begin : g_pass
                // An odd leftover operand rides through this level unchanged.
                always_ff @(posedge clk)
                    node_q[node_offset(k) + j] <= node_q[node_offset(k-1) + 2*j];
            end
        end
    end

    // Valid and channel tags travel alongside the data through every tree level.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl_v_q <= '0;
        end else begin
            lvl_v_q[0] <= mul_v;
            for (int k = 1; k <= LEVELS; k++) lvl_v_q[k] <= lvl_v_q[k-1];
        end
        lvl_ch_q[0] <= mul_ch;
        for (int k = 1; k <= LEVELS; k++) lvl_ch_q[k] <= lvl_ch_q[k-1];
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic                out_valid_q;
    logic [CH_WIDTH-1:0] out_channel_q;
    acc_t                data_out_q;
    logic                ch_err_q;

    // Result and channel update only with a valid result; a bad channel pulses ch_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            data_out_q    <= '0;
            ch_err_q      <= 1'b0;
        end else begin
            out_valid_q <= lvl_v_q[LEVELS];
            ch_err_q    <= in_valid && !ch_ok;
            if (lvl_v_q[LEVELS]) begin
                out_channel_q <= lvl_ch_q[LEVELS];
                data_out_q    <= node_q[ROOT];
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_channel = out_channel_q;
    assign data_out    = data_out_q;
    assign ch_err      = ch_err_q;

endmodule
